// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose: single-port word data memory behind a valid/ready request and
// response handshake. It accepts one load or store at a time, waits LATENCY
// cycles, and then presents the response. The response is held until the CPU
// consumes it.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, 4..4096)
//   LATENCY - wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address (word index taken from bits [log2(DEPTH)+1:2])
//   req_wdata  in   store data
//   req_ready  out  high only in IDLE
//   resp_valid out  high only in RESP
//   resp_rdata out  load data, 0 for stores and rejected requests
//   resp_err   out  misaligned request rejected (optional feature)
//   resp_ready in   CPU consumes the response
//
// Optional feature: define DMEM_MISALIGN_ERR_EN to reject requests whose
// addr[1:0] != 0. A rejected request writes nothing, returns resp_rdata=0 and
// resp_err=1 with normal timing. Without the macro, addr[1:0] is ignored and
// resp_err is tied to 0.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic               we_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [31:0]        wdata_reg;
    logic               bad_req;
    logic               enter_resp;
    logic               mem_we;

    // No reset on the array: contents survive reset.
    logic [31:0]        mem [DEPTH];

    // Address bits outside the word index are deliberately dropped (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:IDX_W+2], req_addr[1:0]};

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);

    // WAIT always lasts cnt+1 cycles, so the response appears exactly
    // LATENCY+1 edges after acceptance; with LATENCY=0 the single WAIT cycle
    // is just the registered memory read.
    assign enter_resp = (state_reg == WAIT) && (cnt_reg == 4'd0);
    assign mem_we     = enter_resp && we_reg && !bad_req;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            we_reg     <= 1'b0;
            idx_reg    <= '0;
            wdata_reg  <= 32'd0;
            resp_rdata <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Request fields are captured only on acceptance, so input
            // activity in WAIT/RESP cannot disturb the pending transaction.
            if (state_reg == IDLE && req_valid) begin
                we_reg    <= req_we;
                idx_reg   <= req_addr[IDX_W+1:2];
                wdata_reg <= req_wdata;
            end
            if (enter_resp) begin
                resp_rdata <= (we_reg || bad_req) ? 32'd0 : mem[idx_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic misalign_reg;
    logic err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                misalign_reg <= (req_addr[1:0] != 2'b00);
            end
            if (enter_resp) begin
                err_reg <= misalign_reg;
            end
        end
    end

    assign bad_req  = misalign_reg;
    assign resp_err = err_reg;
`else
    assign bad_req  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid0, req_valid1;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_ready0, resp_ready1;

    logic        req_ready0, resp_valid0, resp_err0;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata0, resp_rdata1;

    int tests = 0;
    int fails = 0;
    int cur   = 0;

    always #5 clk = ~clk;

    // Instance 0: DEPTH=256, LATENCY=2
    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready0), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .resp_ready(resp_ready0)
    );

    // Instance 1: DEPTH=256, LATENCY=0
    data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready1), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .resp_ready(resp_ready1)
    );

    logic        rq, rv, re;
    logic [31:0] rd;
    assign rq = (cur == 1) ? req_ready1  : req_ready0;
    assign rv = (cur == 1) ? resp_valid1 : resp_valid0;
    assign re = (cur == 1) ? resp_err1   : resp_err0;
    assign rd = (cur == 1) ? resp_rdata1 : resp_rdata0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance sel. Garbage is driven on the request
    // inputs (valid kept high) while the transaction is pending.
    task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold, input string tag);
        int n;
        int lat;
        lat = (sel == 1) ? 0 : 2;
        cur = sel;
        @(negedge clk);
        chk({tag, " req_ready idle"}, {31'd0, rq}, 32'd1);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel == 1) req_valid1 = 1'b1; else req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_we    = ~we;
        req_addr  = addr ^ 32'h4;
        req_wdata = ~wdata;
        chk({tag, " req_ready busy"}, {31'd0, rq}, 32'd0);
        chk({tag, " resp_valid early"}, {31'd0, rv}, 32'd0);
        n = 0;
        while (rv !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat + 1));
        chk({tag, " rdata"}, rd, exp_rdata);
        chk({tag, " err"}, {31'd0, re}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"}, {31'd0, rv}, 32'd1);
            chk({tag, " hold rdata"}, rd, exp_rdata);
            chk({tag, " hold req_ready"}, {31'd0, rq}, 32'd0);
        end
        @(negedge clk);
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        if (sel == 1) resp_ready1 = 1'b1; else resp_ready0 = 1'b1;
        @(posedge clk); #1;
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
        chk({tag, " consumed valid"}, {31'd0, rv}, 32'd0);
        chk({tag, " back to idle"}, {31'd0, rq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mis_rdata;
        logic        mis_err;
        logic [31:0] word10_after;

        reset       = 1'b0;
        req_valid0  = 1'b0;
        req_valid1  = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;

        // Reset state
        #12;
        chk("reset req_ready", {31'd0, req_ready0}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid0}, 32'd0);
        chk("reset rdata", resp_rdata0, 32'd0);
        chk("reset err", {31'd0, resp_err0}, 32'd0);
        chk("reset req_ready L0", {31'd0, req_ready1}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Store then load, LATENCY=2
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "st 0x10");
        txn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "ld 0x10");

        // Response held for 5 cycles
        txn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, "hold ld 0x10");

        // Address wrap: 0x400 -> word index 0 for DEPTH=256
        txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0, 0, "st 0x400");
        txn(0, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 0, "ld 0x0 wrap");

        // Top word
        txn(0, 1'b1, 32'h3FC, 32'h0BADCAFE, 32'h0, 1'b0, 0, "st 0x3fc");
        txn(0, 1'b0, 32'h3FC, 32'h0, 32'h0BADCAFE, 1'b0, 0, "ld 0x3fc");

        // Misaligned store to 0x13
`ifdef DMEM_MISALIGN_ERR_EN
        mis_err      = 1'b1;
        mis_rdata    = 32'h0;
        word10_after = 32'hDEADBEEF;
`else
        mis_err      = 1'b0;
        mis_rdata    = 32'h0;
        word10_after = 32'hCAFEF00D;
`endif
        txn(0, 1'b1, 32'h13, 32'hCAFEF00D, mis_rdata, mis_err, 0, "st 0x13");
        txn(0, 1'b0, 32'h10, 32'h0, word10_after, 1'b0, 0, "ld 0x10 after 0x13");

        // LATENCY=0 instance
        txn(1, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, 0, "L0 st 0x0");
        txn(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 0, "L0 ld 0x0");

        // Reset in the middle of a store
        txn(0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 0, "st 0x20");
        txn(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0, "ld 0x20");
        cur = 0;
        @(negedge clk);
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h22222222;
        req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        chk("rst mid: in wait", {31'd0, req_ready0}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst async req_ready", {31'd0, req_ready0}, 32'd1);
        chk("rst async resp_valid", {31'd0, resp_valid0}, 32'd0);
        chk("rst async rdata", resp_rdata0, 32'd0);
        chk("rst async err", {31'd0, resp_err0}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0, "ld 0x20 after rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
